spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- SPI mode-0 slave front end that feeds the 1 kB RAM stage.
- Deserialises 18-bit MOSI frames (2-bit opcode + 16-bit payload) into rx_data/rx_valid.
- For READ_DATA (opcode 2'b11), captures the RAM's returned word and serialises its 16 LSBs back on MISO within the same ss_n window.
- All SPI pins are oversampled in the sys_clock domain; no SCLK-clocked flops.

Parameters:
- FRAME_W, 18, MOSI command frame length in bits (opcode + payload).
- DATA_W, 16, readback length in bits shifted on MISO.
- SYNC_STAGES, 2, synchroniser depth on sclk, mosi and ss_n.

Ports:
- sys_clock  input  1  system clock; must be ≥16× SCLK frequency.
- reset_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI clock from master, idle low.
- mosi  input  1  master-out data, MSB first.
- ss_n  input  1  active-low slave select.
- miso  output  1  slave-out data, MSB first.
- rx_data  output  FRAME_W  completed frame to RAM; [17:16] opcode, [15:0] payload.
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  FRAME_W  RAM read result; [15:0] used.
- tx_valid  input  1  RAM read result valid.

Behaviour:
- Clock is sys_clock; reset is reset_n, asynchronous, active-low. All state is clocked on posedge sys_clock.
- Reset values: miso=0, rx_data=0, rx_valid=0, bit counter=0, state=IDLE. Synchroniser flops reset to sclk=0, mosi=0, ss_n=1.
- Synchronisation and edge detection:
  - sclk, mosi and ss_n each pass through SYNC_STAGES flops.
  - sclk_rise/sclk_fall come from the synchronised sclk versus its one-cycle-delayed copy.
- States and transitions:
  - IDLE: miso=0. Synchronised ss_n low → RX with bit counter cleared.
  - RX: on each sclk_rise, shift mosi into the LSB of an 18-bit shift register and increment the counter. On the FRAME_W-th rise:
    - next cycle: rx_data ← shift register, rx_valid=1 for exactly one cycle;
    - opcode 2'b11 → WAIT_RD; otherwise → DRAIN.
  - WAIT_RD: the RAM presents tx_data with tx_valid=1 one cycle after rx_valid, and holds tx_data for that one cycle only. In the first cycle with tx_valid=1:
    - load tx_data[15:0] into the TX shift register;
    - miso = TX MSB;
    - clear the counter; → TX.
    - sclk edges seen in WAIT_RD are ignored.
  - TX: miso always reflects the TX shift register MSB.
    - Each sclk_fall that follows an sclk_rise seen in TX shifts left by one (zero fill).
    - After DATA_W rises → DRAIN.
  - DRAIN: miso=0; all sclk activity ignored until ss_n high.
- Abort and gap rules:
  - ss_n high in any state → IDLE next cycle. The partial frame is discarded (no rx_valid) and miso=0.
  - A new frame requires ss_n to return high first; back-to-back frames need ≥2 sys_clock cycles of ss_n high.
- Latency:
  - 18th SCLK rise to rx_valid: SYNC_STAGES+2 sys_clock cycles.
  - rx_valid to miso loaded: 2 cycles.
  - Worst case ≤6 cycles, which fits inside half an SCLK period at 16× oversampling.
- Data path: rx_valid is never asserted for frames shorter than FRAME_W bits. Bits beyond FRAME_W (non-read) or FRAME_W+DATA_W (read) are ignored.
- Reset mid-frame: all outputs return to reset values immediately, asynchronously.

Optional Feature:
- Macro SPI_RD_TIMEOUT_EN.
- When defined:
  - WAIT_RD has a 4-bit cycle counter.
  - If tx_valid has not been seen within 8 cycles → DRAIN, and a 1-cycle pulse is driven on added output port rd_err (1 bit, reset 0).
- When undefined: no rd_err port; WAIT_RD waits indefinitely until tx_valid or ss_n high.

Test Plan:
- Write frame 18'b00_0000_0000_0000_0101 then, in a new ss_n window, 18'b01_1010_1011_1100_1101 → two single-cycle rx_valid strobes carrying rx_data=18'h00005 and 18'h1ABCD; miso=0 throughout.
- Read address 18'h20005, then 34-clock frame 18'h30000 with the RAM model returning 18'h0ABCD → rx_valid once with rx_data=18'h30000; master samples miso bits 16'hABCD MSB first on clocks 19–34.
- Raise ss_n after 9 sclk rises, then send a full frame 18'h1FFFF → no rx_valid for the partial frame; exactly one rx_valid carrying 18'h1FFFF.
- Assert reset_n=0 during the TX phase of a read → miso=0 and rx_valid=0 asynchronously; state IDLE; the next frame is received correctly.
- Send a 24-clock non-read frame starting 18'h00010 → one rx_valid with rx_data=18'h00010; the extra 6 bits are ignored; miso stays 0.
- With SPI_RD_TIMEOUT_EN defined, send opcode 2'b11 with tx_valid held 0 → rd_err pulses once, 8 cycles after rx_valid; miso stays 0.

Source files
------------

// File: rtl/spi_slave_if_if.sv
// Bundle of SPI pins and RAM handshake for the SPI slave front end.
//   sclk, mosi, ss_n : SPI master -> slave
//   miso             : slave -> SPI master
//   rx_data/rx_valid : completed command frame towards the RAM stage
//   tx_data/tx_valid : RAM read result back to the slave
//   rd_err           : read-timeout pulse, present only with SPI_RD_TIMEOUT_EN
interface spi_slave_if_if #(
    parameter int unsigned FRAME_W = 18
);
    logic               sclk;
    logic               mosi;
    logic               ss_n;
    logic               miso;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [FRAME_W-1:0] tx_data;
    logic               tx_valid;
`ifdef SPI_RD_TIMEOUT_EN
    logic               rd_err;
`endif

    modport slave (
        input  sclk, mosi, ss_n, tx_data, tx_valid,
`ifdef SPI_RD_TIMEOUT_EN
        output rd_err,
`endif
        output miso, rx_data, rx_valid
    );

    modport master (
        output sclk, mosi, ss_n, tx_data, tx_valid,
`ifdef SPI_RD_TIMEOUT_EN
        input  rd_err,
`endif
        input  miso, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end for the RAM stage, fully oversampled in sys_clock.
// Deserialises FRAME_W-bit MOSI frames (2-bit opcode + payload) into rx_data/rx_valid;
// for READ_DATA (2'b11) it captures the RAM word and shifts DATA_W bits back on MISO.
// Ports:
//   sys_clock, reset_n : system clock (>= 16x SCLK), async active-low reset
//   bus (slave modport): sclk/mosi/ss_n in, miso out, rx_data/rx_valid out,
//                        tx_data/tx_valid in, rd_err out (timeout build only)
// Optional feature macro: SPI_RD_TIMEOUT_EN -- gives up on a RAM read after 8 cycles
// in WAIT_RD and pulses rd_err.
module spi_slave_if #(
    parameter int unsigned FRAME_W     = 18,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          sys_clock,
    input  logic          reset_n,
    spi_slave_if_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(FRAME_W + DATA_W + 1);
    localparam int unsigned OP_W  = 2;
    localparam logic [OP_W-1:0] OP_READ_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_WAIT_RD,
        ST_TX,
        ST_DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]     rx_shift_q, rx_shift_d;
    logic [FRAME_W-1:0]     rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
    logic                   rise_seen_q, rise_seen_d;
    logic                   miso_q, miso_d;

    logic sclk_s, mosi_s, ss_s;
    logic sclk_rise_c, sclk_fall_c;
    logic frame_done_c, tx_last_c;
    logic unused_tx_hi_c;

`ifdef SPI_RD_TIMEOUT_EN
    localparam int unsigned TMO_W      = 4;
    localparam int unsigned TMO_CYCLES = 8;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rd_err_q, rd_err_d;
    logic             tmo_hit_c;
`endif

    // Synchroniser chains: newest sample enters at bit 0, oldest falls off the top
    always_comb begin
        sclk_sync_d = SYNC_STAGES'({sclk_sync_q, bus.sclk});
        mosi_sync_d = SYNC_STAGES'({mosi_sync_q, bus.mosi});
        ss_sync_d   = SYNC_STAGES'({ss_sync_q, bus.ss_n});
        sclk_dly_d  = sclk_s;
    end

    assign sclk_s       = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s         = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise_c  = sclk_s & ~sclk_dly_q;
    assign sclk_fall_c  = ~sclk_s & sclk_dly_q;
    assign frame_done_c = (bit_cnt_q == CNT_W'(FRAME_W));
    assign tx_last_c    = sclk_rise_c && (bit_cnt_q == CNT_W'(DATA_W - 1));
    // Opcode bits of the RAM word are not returned on MISO
    assign unused_tx_hi_c = ^bus.tx_data[FRAME_W-1:DATA_W];

`ifdef SPI_RD_TIMEOUT_EN
    assign tmo_hit_c = !bus.tx_valid && (tmo_cnt_q == TMO_W'(TMO_CYCLES - 1));
`endif

    // State register
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ss_n high aborts from anywhere
    always_comb begin
        state_d = state_q;
        if (ss_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RX;
                ST_RX: begin
                    if (frame_done_c) begin
                        state_d = (rx_shift_q[FRAME_W-1 -: OP_W] == OP_READ_DATA) ? ST_WAIT_RD
                                                                                  : ST_DRAIN;
                    end
                end
                ST_WAIT_RD: begin
                    if (bus.tx_valid) begin
                        state_d = ST_TX;
                    end
`ifdef SPI_RD_TIMEOUT_EN
                    else if (tmo_hit_c) begin
                        state_d = ST_DRAIN;
                    end
`endif
                end
                ST_TX: begin
                    if (tx_last_c) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: state_d = ST_DRAIN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        rise_seen_d = rise_seen_q;
`ifdef SPI_RD_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rd_err_d    = 1'b0;
`endif
        if (ss_s) begin
            bit_cnt_d   = '0;
            rise_seen_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: bit_cnt_d = '0;
                ST_RX: begin
                    if (frame_done_c) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
`ifdef SPI_RD_TIMEOUT_EN
                        tmo_cnt_d  = '0;
`endif
                    end else if (sclk_rise_c) begin
                        rx_shift_d = {rx_shift_q[FRAME_W-2:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_RD: begin
                    // RAM holds tx_data for one cycle only, so capture it immediately
                    if (bus.tx_valid) begin
                        tx_shift_d  = bus.tx_data[DATA_W-1:0];
                        bit_cnt_d   = '0;
                        rise_seen_d = 1'b0;
                    end
`ifdef SPI_RD_TIMEOUT_EN
                    else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        rd_err_d  = tmo_hit_c;
                    end
`endif
                end
                ST_TX: begin
                    // Only a fall preceded by a rise in TX advances the data, so the
                    // trailing fall of the command frame never drops bit 15
                    if (sclk_rise_c) begin
                        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                        rise_seen_d = 1'b1;
                    end else if (sclk_fall_c && rise_seen_q) begin
                        tx_shift_d  = {tx_shift_q[DATA_W-2:0], 1'b0};
                        rise_seen_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        miso_d = (state_d == ST_TX) ? tx_shift_d[DATA_W-1] : 1'b0;
    end

    // Datapath registers
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_dly_q  <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            rise_seen_q <= 1'b0;
            miso_q      <= 1'b0;
`ifdef SPI_RD_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            rd_err_q    <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            rise_seen_q <= rise_seen_d;
            miso_q      <= miso_d;
`ifdef SPI_RD_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            rd_err_q    <= rd_err_d;
`endif
        end
    end

    assign bus.miso     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`ifdef SPI_RD_TIMEOUT_EN
    assign bus.rd_err   = rd_err_q;
`endif
endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: a SPI master task drives frames, a RAM model
// answers READ_DATA, and a monitor checks every rx_valid against queued expectations.
module tb_spi_slave_if;
    localparam int unsigned FRAME_W = 18;
    localparam int unsigned DATA_W  = 16;
    localparam int          HALF    = 8;   // sys_clock cycles per SCLK half period

    logic sys_clock = 1'b0;
    logic reset_n   = 1'b0;

    spi_slave_if_if #(.FRAME_W(FRAME_W)) bus ();

    spi_slave_if #(
        .FRAME_W    (FRAME_W),
        .DATA_W     (DATA_W),
        .SYNC_STAGES(2)
    ) dut (
        .sys_clock(sys_clock),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 sys_clock = ~sys_clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;
    logic [17:0] exp_rx_q[$];
    logic [15:0] exp_rd_q[$];
    logic [15:0] mem[256];
    logic [7:0]  waddr = 8'h0;
    logic [7:0]  raddr = 8'h0;
    bit          ram_en = 1'b1;
    bit          prev_rxv = 1'b0;
    int          rderr_cnt = 0;
    longint      last_rxv_cyc = 0;

    always @(posedge sys_clock) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rx_valid strobe must match the next queued frame
    always @(negedge sys_clock) begin
        if (reset_n) begin
            if (prev_rxv) chk_eq("rx_valid_one_cycle", 64'(bus.rx_valid), 64'd0);
            if (bus.rx_valid) begin
                chk_eq("rx_expected_pending", 64'(exp_rx_q.size() != 0), 64'd1);
                if (exp_rx_q.size() != 0) chk_eq("rx_data", 64'(bus.rx_data), 64'(exp_rx_q.pop_front()));
                last_rxv_cyc = cyc;
            end
`ifdef SPI_RD_TIMEOUT_EN
            if (bus.rd_err) begin
                rderr_cnt++;
                chk_eq("rd_err_latency", 64'(cyc - last_rxv_cyc), 64'd8);
            end
`endif
            prev_rxv = bus.rx_valid;
        end else begin
            prev_rxv = 1'b0;
        end
    end

    // RAM model: 00 write addr, 01 write data, 10 read addr, 11 return mem[read addr]
    initial begin : ram_model
        logic [17:0] f;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        forever begin
            @(negedge sys_clock);
            if (reset_n && bus.rx_valid) begin
                f = bus.rx_data;
                case (f[17:16])
                    2'b00: waddr = f[7:0];
                    2'b01: mem[waddr] = f[15:0];
                    2'b10: raddr = f[7:0];
                    default: begin
                        if (ram_en) begin
                            @(negedge sys_clock);
                            bus.tx_data  = {2'($urandom), mem[raddr]};
                            bus.tx_valid = 1'b1;
                            exp_rd_q.push_back(mem[raddr]);
                            @(negedge sys_clock);
                            bus.tx_valid = 1'b0;
                            bus.tx_data  = 18'($urandom);
                        end
                    end
                endcase
            end
        end
    end

    task automatic sclk_half();
        repeat (HALF) @(negedge sys_clock);
    endtask

    // SPI mode-0 master; so collects miso as seen at each rising edge, MSB first
    task automatic spi_frame(input logic [63:0] bits, input int nbits, input int abort_at,
                             input int reset_at, output logic [63:0] so);
        so = '0;
        bus.ss_n = 1'b0;
        sclk_half();
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = bits[nbits-1-i];
            sclk_half();
            so = {so[62:0], bus.miso};
            bus.sclk = 1'b1;
            if (i + 1 == reset_at) begin
                repeat (3) @(negedge sys_clock);
                #2 reset_n = 1'b0;
                #1;
                chk_eq("reset_miso", 64'(bus.miso), 64'd0);
                chk_eq("reset_rx_valid", 64'(bus.rx_valid), 64'd0);
                chk_eq("reset_rx_data", 64'(bus.rx_data), 64'd0);
                bus.sclk = 1'b0;
                bus.ss_n = 1'b1;
                bus.mosi = 1'b0;
                repeat (4) @(negedge sys_clock);
                reset_n = 1'b1;
                repeat (4) @(negedge sys_clock);
                return;
            end
            sclk_half();
            bus.sclk = 1'b0;
            if (i + 1 == abort_at) break;
        end
        sclk_half();
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (6) @(negedge sys_clock);
    endtask

    // One transaction: reads clock FRAME_W+DATA_W bits, others FRAME_W+extra
    task automatic send(input logic [17:0] frame, input int extra, input int abort_at, input int reset_at);
        logic [63:0] bits, so, pad;
        logic [15:0] rd_exp;
        int          n, x;
        bit          is_rd, full;
        is_rd = (frame[17:16] == 2'b11);
        x     = is_rd ? DATA_W : extra;
        n     = FRAME_W + x;
        pad   = (64'd1 << x) - 64'd1;
        bits  = (64'(frame) << x) | ({$urandom, $urandom} & pad);
        full  = (abort_at == 0);
        if (full) exp_rx_q.push_back(frame);
        spi_frame(bits, n, abort_at, reset_at, so);
        if (reset_at != 0) begin
            chk_eq("rd_issued_before_reset", 64'(exp_rd_q.size()), 64'd1);
            if (exp_rd_q.size() != 0) rd_exp = exp_rd_q.pop_front();
        end else if (full) begin
            if (is_rd && ram_en) begin
                chk_eq("miso_cmd_phase", so[33:16], 64'd0);
                chk_eq("rd_response_seen", 64'(exp_rd_q.size() != 0), 64'd1);
                if (exp_rd_q.size() != 0) begin
                    rd_exp = exp_rd_q.pop_front();
                    chk_eq("miso_readback", 64'(so[15:0]), 64'(rd_exp));
                end
            end else begin
                chk_eq("miso_idle", so, 64'd0);
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [17:0] fr;
        int          r;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.ss_n = 1'b1;
        repeat (3) @(negedge sys_clock);
        chk_eq("rst_miso", 64'(bus.miso), 64'd0);
        chk_eq("rst_rx_valid", 64'(bus.rx_valid), 64'd0);
        chk_eq("rst_rx_data", 64'(bus.rx_data), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge sys_clock);

        // Writes: address 5 then data ABCD
        send(18'h00005, 0, 0, 0);
        send(18'h1ABCD, 0, 0, 0);
        // Read back address 5
        send(18'h20005, 0, 0, 0);
        send(18'h30000, 0, 0, 0);
        // Partial frame discarded, then a full one
        send(18'h2A5A5, 0, 9, 0);
        send(18'h1FFFF, 0, 0, 0);
        // Reset during TX, then recovery with an over-long non-read frame
        send(18'h20005, 0, 0, 0);
        send(18'h30000, 0, 0, 25);
        send(18'h00010, 6, 0, 0);
        // RAM never answers
        ram_en = 1'b0;
        send(18'h30000, 0, 0, 0);
        ram_en = 1'b1;
`ifdef SPI_RD_TIMEOUT_EN
        chk_eq("rd_err_pulses", 64'(rderr_cnt), 64'd1);
`endif
        // Random traffic
        for (int k = 0; k < 24; k++) begin
            fr = 18'($urandom);
            r  = $urandom_range(0, 9);
            if (r == 0) send(fr, 0, $urandom_range(1, 17), 0);
            else        send(fr, (fr[17:16] == 2'b11) ? 0 : $urandom_range(0, 6), 0, 0);
        end
        repeat (10) @(negedge sys_clock);
        chk_eq("rx_queue_drained", 64'(exp_rx_q.size()), 64'd0);
        chk_eq("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
